// File: rtl/secure_store_fsm.sv
// Access controller: multi-digit code entry, failed-attempt lockout, and
// a logged-in session that routes each store to one of CHANNELS enables.
module secure_store_fsm #(
  parameter int DATA_WIDTH     = 4,
  parameter int CODE_LENGTH    = 2,
  parameter logic [DATA_WIDTH*CODE_LENGTH-1:0] CODE = 8'h96,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int CHANNELS       = 2
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                request,
  input  logic                                confirm,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic [CHANNELS-1:0]                 output_enable,
  output logic                                logged_in,
  output logic                                locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   fail_count
);

  localparam int SEL   = $clog2(CHANNELS);
  localparam int IDX_W = (CODE_LENGTH > 1) ? $clog2(CODE_LENGTH) : 1;
  localparam int FC_W  = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LENGTH - 1);
  localparam logic [FC_W-1:0]  MAX_FC   = FC_W'(MAX_ATTEMPTS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, LOGGED_IN, LOCKOUT} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      index_reg, index_next;
  logic                  mismatch_reg, mismatch_next;
  logic [FC_W-1:0]       fail_reg, fail_next;
  logic [TMR_W-1:0]      timer_reg, timer_next;
  logic [DATA_WIDTH-1:0] dout_reg, dout_next;
  logic [CHANNELS-1:0]   oe_reg, oe_next;
  logic                  logged_in_reg, locked_reg;

  logic [DATA_WIDTH-1:0] code_digit [CODE_LENGTH];
  logic                  mismatch_any;

  genvar gi;
  generate
    for (gi = 0; gi < CODE_LENGTH; gi++) begin : g_digit
      assign code_digit[gi] = CODE[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Includes the digit being confirmed this cycle, so the final judgement
  // sees every digit of the attempt.
  assign mismatch_any = mismatch_reg | (data_in != code_digit[index_reg]);

  always_comb begin
    state_next    = state_reg;
    index_next    = index_reg;
    mismatch_next = mismatch_reg;
    fail_next     = fail_reg;
    timer_next    = timer_reg;
    dout_next     = dout_reg;
    oe_next       = '0;
    case (state_reg)
      IDLE: begin
        index_next    = '0;
        mismatch_next = 1'b0;
        if (request) state_next = ENTRY;
      end
      ENTRY: begin
        if (!request) begin
          state_next = IDLE;
        end else if (confirm) begin
          if (index_reg == LAST_IDX) begin
            index_next    = '0;
            mismatch_next = 1'b0;
            if (!mismatch_any) begin
              state_next = LOGGED_IN;
              fail_next  = '0;
            end else if (fail_reg + 1'b1 == MAX_FC) begin
              state_next = LOCKOUT;
              fail_next  = MAX_FC;
              timer_next = TMR_LOAD;
            end else begin
              fail_next = fail_reg + 1'b1;
            end
          end else begin
            index_next    = index_reg + 1'b1;
            mismatch_next = mismatch_any;
          end
        end
      end
      LOGGED_IN: begin
        if (!request) begin
          state_next = IDLE;
        end else if (confirm) begin
          dout_next = data_in;
          oe_next   = CHANNELS'(1) << data_in[SEL-1:0];
        end
      end
      LOCKOUT: begin
        // Request and confirm are deliberately ignored until the timer expires.
        if (timer_reg == '0) begin
          state_next = IDLE;
          fail_next  = '0;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      mismatch_reg  <= 1'b0;
      fail_reg      <= '0;
      timer_reg     <= '0;
      dout_reg      <= '0;
      oe_reg        <= '0;
      logged_in_reg <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      mismatch_reg  <= mismatch_next;
      fail_reg      <= fail_next;
      timer_reg     <= timer_next;
      dout_reg      <= dout_next;
      oe_reg        <= oe_next;
      logged_in_reg <= (state_next == LOGGED_IN);
      locked_reg    <= (state_next == LOCKOUT);
    end
  end

  assign data_out      = dout_reg;
  assign output_enable = oe_reg;
  assign logged_in     = logged_in_reg;
  assign locked        = locked_reg;
  assign fail_count    = fail_reg;

endmodule

// File: tb/tb_secure_store_fsm.sv
// Directed bench for secure_store_fsm: vector table for login/store/fail
// paths, plus sequences for lockout duration and asynchronous reset.
module tb_secure_store_fsm;

  logic       clock;
  logic       reset_n;
  logic       request;
  logic       confirm;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic [1:0] output_enable;
  logic       logged_in;
  logic       locked;
  logic [1:0] fail_count;

  int checks = 0;
  int errors = 0;

  secure_store_fsm dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .request       (request),
    .confirm       (confirm),
    .data_in       (data_in),
    .data_out      (data_out),
    .output_enable (output_enable),
    .logged_in     (logged_in),
    .locked        (locked),
    .fail_count    (fail_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       req;
    logic       conf;
    logic [3:0] din;
    logic       exp_li;
    logic       exp_lk;
    logic [1:0] exp_fc;
    logic [1:0] exp_oe;
    logic [3:0] exp_do;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic cyc(input logic r, input logic c, input logic [3:0] d);
    request = r;
    confirm = c;
    data_in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic li, input logic lk,
                         input logic [1:0] fc, input logic [1:0] oe, input logic [3:0] dout);
    chk({tag, ".logged_in"}, 32'(logged_in), 32'(li));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".fail_count"}, 32'(fail_count), 32'(fc));
    chk({tag, ".output_enable"}, 32'(output_enable), 32'(oe));
    chk({tag, ".data_out"}, 32'(data_out), 32'(dout));
  endtask

  initial begin
    //          req  conf din    li    lk    fc     oe      do
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 4'h0};
    vecs[1]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 2'd0, 2'b00, 4'h0};
    vecs[2]  = '{1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 2'd0, 2'b00, 4'h0};
    vecs[3]  = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 2'd0, 2'b10, 4'h5};
    vecs[4]  = '{1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 2'd0, 2'b01, 4'hA};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 2'b00, 4'hA};
    vecs[6]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 2'd0, 2'b00, 4'hA};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 4'hA};
    vecs[8]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 2'd0, 2'b00, 4'hA};
    vecs[9]  = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 2'd1, 2'b00, 4'hA};
    vecs[10] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 2'd1, 2'b00, 4'hA};
    vecs[11] = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 2'd2, 2'b00, 4'hA};
    vecs[12] = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 2'd2, 2'b00, 4'hA};
    vecs[13] = '{1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 2'd0, 2'b00, 4'hA};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 4'hA};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 4'hA};
    vecs[16] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 2'd0, 2'b00, 4'hA};
    vecs[17] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 2'd1, 2'b00, 4'hA};
    vecs[18] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 2'd1, 2'b00, 4'hA};
    vecs[19] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 2'd2, 2'b00, 4'hA};
    vecs[20] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 2'd2, 2'b00, 4'hA};
    vecs[21] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 2'd3, 2'b00, 4'hA};

    reset_n = 1'b0;
    request = 1'b0;
    confirm = 1'b0;
    data_in = 4'h0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 2'd0, 2'b00, 4'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].req, vecs[i].conf, vecs[i].din);
      $display("vec %0d: req=%0b conf=%0b din=%h -> li=%0b lk=%0b fc=%0d oe=%b do=%h",
               i, vecs[i].req, vecs[i].conf, vecs[i].din,
               logged_in, locked, fail_count, output_enable, data_out);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_li, vecs[i].exp_lk,
              vecs[i].exp_fc, vecs[i].exp_oe, vecs[i].exp_do);
    end

    // Locked already for one cycle; 15 more with request toggling and confirm held.
    for (int i = 1; i < 16; i++) begin
      cyc(i[0], 1'b1, 4'h6);
      $display("lockout cycle %0d: lk=%0b fc=%0d", i, locked, fail_count);
      chk_all($sformatf("lock%0d", i), 1'b0, 1'b1, 2'd3, 2'b00, 4'hA);
    end
    cyc(1'b1, 1'b0, 4'h0);
    $display("lockout expiry: lk=%0b fc=%0d", locked, fail_count);
    chk_all("lock_exit", 1'b0, 1'b0, 2'd0, 2'b00, 4'hA);

    // IDLE -> ENTRY, then the correct code must log in.
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'h6);
    chk("relogin_partial.logged_in", 32'(logged_in), 32'd0);
    cyc(1'b1, 1'b1, 4'h9);
    $display("relogin after lockout: li=%0b fc=%0d", logged_in, fail_count);
    chk_all("relogin", 1'b1, 1'b0, 2'd0, 2'b00, 4'hA);

    cyc(1'b1, 1'b1, 4'h7);
    $display("store 7: oe=%b do=%h", output_enable, data_out);
    chk_all("store7", 1'b1, 1'b0, 2'd0, 2'b10, 4'h7);
    cyc(1'b1, 1'b0, 4'h0);
    chk("store7_pulse_end.output_enable", 32'(output_enable), 32'd0);

    // Partial attempt then logout: failure count must survive request=0.
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'h1);
    cyc(1'b1, 1'b1, 4'h1);
    chk("partial_fail.fail_count", 32'(fail_count), 32'd1);
    cyc(1'b1, 1'b1, 4'h6);
    cyc(1'b0, 1'b0, 4'h0);
    $display("logout mid-attempt: fc=%0d", fail_count);
    chk("logout_keeps.fail_count", 32'(fail_count), 32'd1);
    cyc(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 4'h5);
    $display("second lockout: lk=%0b fc=%0d", locked, fail_count);
    chk_all("lock2", 1'b0, 1'b1, 2'd3, 2'b00, 4'h7);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0);

    // Asynchronous reset between edges, no clock edge before sampling.
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset in lockout: lk=%0b fc=%0d do=%h", locked, fail_count, data_out);
    chk_all("async_reset", 1'b0, 1'b0, 2'd0, 2'b00, 4'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'h6);
    cyc(1'b1, 1'b1, 4'h9);
    $display("login after reset: li=%0b fc=%0d", logged_in, fail_count);
    chk_all("post_reset_login", 1'b1, 1'b0, 2'd0, 2'b00, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
